condition_unit: RTL and testbench

CONDITION_UNIT -- requirements
Module: condition_unit

---
 rtl/condition_unit_pkg.sv | 32 +++
 rtl/condition_unit_if.sv | 28 ++
 rtl/condition_unit_cond_eval.sv | 40 ++++
 rtl/condition_unit.sv | 100 ++++++++++
 tb/tb_condition_unit.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/condition_unit_pkg.sv
// Shared scalar ALU definitions: flag bit positions and condition-code encoding.
// Used by condition_unit and cond_eval.
package condition_unit_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // Wide enough for the largest legal PEND_MAX (7).
  localparam int PEND_W = 3;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_code_e;

endpackage

// File: rtl/condition_unit_if.sv
// Issue, ALU flag-write and condition-query signals of condition_unit.
// Master is the pipeline side, slave is condition_unit.
interface condition_unit_if;
  // Handshake: a query transfers on a cycle where cond_valid && cond_ready.
  // The requester holds cond_valid and cond_code steady until then. The result
  // appears as a one-cycle res_valid pulse on the following cycle and cannot be
  // stalled. Issues transfer when issue_flag_op && issue_ready.
  logic       issue_flag_op;
  logic       issue_ready;
  logic       alu_valid;
  logic       flag_we;
  logic [3:0] flags_in;
  logic       cond_valid;
  logic [3:0] cond_code;
  logic       cond_ready;
  logic       res_valid;
  logic       res_taken;

  modport master (
    output issue_flag_op, alu_valid, flag_we, flags_in, cond_valid, cond_code,
    input  issue_ready, cond_ready, res_valid, res_taken
  );

  modport slave (
    input  issue_flag_op, alu_valid, flag_we, flags_in, cond_valid, cond_code,
    output issue_ready, cond_ready, res_valid, res_taken
  );
endinterface

// File: rtl/condition_unit_cond_eval.sv
// Combinational condition decoder: {N,Z,V,C} flags and condition code -> taken.
module cond_eval
  import condition_unit_pkg::*;
(
  input  logic [3:0] flags_i,
  input  cond_code_e code_i,
  output logic       taken_o
);

  logic n, z, v, c;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign v = flags_i[FLAG_V];
  assign c = flags_i[FLAG_C];

  always_comb begin
    taken_o = 1'b0;
    case (code_i)
      COND_EQ: taken_o = z;
      COND_NE: taken_o = !z;
      COND_CS: taken_o = c;
      COND_CC: taken_o = !c;
      COND_MI: taken_o = n;
      COND_PL: taken_o = !n;
      COND_VS: taken_o = v;
      COND_VC: taken_o = !v;
      COND_HI: taken_o = c && !z;
      COND_LS: taken_o = !c || z;
      COND_GE: taken_o = (n == v);
      COND_LT: taken_o = (n != v);
      COND_GT: taken_o = !z && (n == v);
      COND_LE: taken_o = z || (n != v);
      COND_AL: taken_o = 1'b1;
      COND_NV: taken_o = 1'b0;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/condition_unit.sv
// Condition unit: architectural NZVC register, pending flag-op tracking and
// hazard-checked condition queries. Optional macro COND_BYPASS_EN adds flag bypass.
module condition_unit
  import condition_unit_pkg::*;
#(
  parameter int unsigned PEND_MAX = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  condition_unit_if.slave        bus,
  output logic [3:0]             flags_q,
  output logic                   err_underflow
);

  localparam logic [PEND_W-1:0] PEND_LIM = PEND_MAX[PEND_W-1:0];

  logic [PEND_W-1:0] pend_q, pend_d;
  logic [3:0]        flags_d;
  logic              err_q, err_d;
  logic              res_valid_q, res_valid_d;
  logic              res_taken_q, res_taken_d;

  logic              flag_wr;
  logic              issue_acc;
  logic              permit;
  logic              use_bypass;
  logic              query_acc;
  logic [3:0]        eval_flags;
  logic              taken;

  assign flag_wr   = bus.alu_valid && bus.flag_we;
  assign issue_acc = bus.issue_flag_op && (pend_q < PEND_LIM);

`ifdef COND_BYPASS_EN
  // The last outstanding flag op retires this cycle: evaluate on its flags directly.
  assign use_bypass = (pend_q == PEND_W'(1)) && flag_wr && !issue_acc;
  assign eval_flags = use_bypass ? bus.flags_in : flags_q;
`else
  assign use_bypass = 1'b0;
  assign eval_flags = flags_q;
`endif

  assign permit    = (pend_q == '0) || use_bypass;
  assign query_acc = bus.cond_valid && permit && !rst;

  assign bus.issue_ready = rst || (pend_q < PEND_LIM);
  assign bus.cond_ready  = query_acc;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_taken   = res_taken_q;
  assign err_underflow   = err_q;

  cond_eval u_cond_eval (
    .flags_i (eval_flags),
    .code_i  (cond_code_e'(bus.cond_code)),
    .taken_o (taken)
  );

  always_comb begin
    pend_d      = pend_q;
    flags_d     = flags_q;
    err_d       = err_q;
    res_valid_d = query_acc;
    res_taken_d = res_taken_q;

    if (issue_acc && !flag_wr) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (flag_wr && !issue_acc && (pend_q != '0)) begin
      pend_d = pend_q - PEND_W'(1);
    end

    // A write with nothing outstanding still updates the flags but is flagged.
    if (flag_wr) begin
      flags_d = bus.flags_in;
      if (pend_q == '0) begin
        err_d = 1'b1;
      end
    end

    if (query_acc) begin
      res_taken_d = taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      flags_q     <= 4'b0000;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
    end
  end

endmodule

// File: tb/tb_condition_unit.sv
// Testbench for condition_unit: directed scenarios, a full decode sweep and
// randomized traffic, all checked against a behavioural model every cycle.
module tb_condition_unit;
  import condition_unit_pkg::*;

  localparam int PEND_MAX = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] flags_q;
  logic       err_underflow;

  condition_unit_if bus_if();

  condition_unit #(.PEND_MAX(PEND_MAX)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_if),
    .flags_q       (flags_q),
    .err_underflow (err_underflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_flags;
  int         m_pend;
  bit         m_err;
  bit         m_rv;
  bit         m_last_taken;
  bit         m_qacc;
  bit         m_live = 1'b0;
  logic [0:0] exp_q[$];

  bit         mfw, macc, mt;
  logic [3:0] meff;

  function automatic bit taken_of(input logic [3:0] f, input logic [3:0] code);
    bit n, z, v, c;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_cond_ready();
    bit fw, acc;
    fw  = bus_if.alu_valid && bus_if.flag_we;
    acc = bus_if.issue_flag_op && (m_pend < PEND_MAX);
    if (rst || !bus_if.cond_valid) return 1'b0;
    if (m_pend == 0) return 1'b1;
`ifdef COND_BYPASS_EN
    if (m_pend == 1 && fw && !acc) return 1'b1;
`else
    if (fw && acc) return 1'b0;
`endif
    return 1'b0;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_flags = 4'b0000; m_pend = 0; m_err = 1'b0;
      m_rv = 1'b0; m_last_taken = 1'b0; m_qacc = 1'b0;
      exp_q.delete();
      m_live = 1'b1;
    end else if (m_live) begin
      mfw    = bus_if.alu_valid && bus_if.flag_we;
      macc   = bus_if.issue_flag_op && (m_pend < PEND_MAX);
      m_qacc = m_cond_ready();
      m_rv   = m_qacc;
      if (m_qacc) begin
        meff = (m_pend == 0) ? m_flags : bus_if.flags_in;
        mt   = taken_of(meff, bus_if.cond_code);
        exp_q.push_back(mt);
        m_last_taken = mt;
      end
      if (mfw) begin
        m_flags = bus_if.flags_in;
        if (m_pend == 0) m_err = 1'b1;
      end
      m_pend = m_pend + int'(macc) - int'(mfw);
      if (m_pend < 0) m_pend = 0;
    end
  end

  // ---------------- compare process ----------------
  logic [0:0] popped;
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check("issue_ready", 32'(bus_if.issue_ready), 32'(rst || (m_pend < PEND_MAX)));
      check("cond_ready",  32'(bus_if.cond_ready),  32'(m_cond_ready()));
      check("res_valid",   32'(bus_if.res_valid),   32'(m_rv));
      check("res_taken",   32'(bus_if.res_taken),   32'(m_last_taken));
      check("flags_q",     32'(flags_q),            32'(m_flags));
      check("err_underflow", 32'(err_underflow),    32'(m_err));
      if (m_rv && exp_q.size() > 0) begin
        popped = exp_q.pop_front();
        check("res_taken_q", 32'(bus_if.res_taken), 32'(popped));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    #1;
  endtask

  task automatic idle();
    bus_if.issue_flag_op = 1'b0;
    bus_if.alu_valid     = 1'b0;
    bus_if.flag_we       = 1'b0;
    bus_if.flags_in      = 4'b0000;
    bus_if.cond_valid    = 1'b0;
    bus_if.cond_code     = 4'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic flag_write(input logic [3:0] f);
    bus_if.alu_valid = 1'b1;
    bus_if.flag_we   = 1'b1;
    bus_if.flags_in  = f;
  endtask

  task automatic flag_off();
    bus_if.alu_valid = 1'b0;
    bus_if.flag_we   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle();

    // Reset state, then flag write 0100 and EQ query.
    do_reset();
    peek();
    check("rst_flags", 32'(flags_q), 32'h0);
    check("rst_err", 32'(err_underflow), 32'h0);
    check("rst_res_valid", 32'(bus_if.res_valid), 32'h0);
    check("rst_issue_ready", 32'(bus_if.issue_ready), 32'h1);
    flag_write(4'b0100);
    step();
    flag_off();
    bus_if.cond_valid = 1'b1;
    bus_if.cond_code  = COND_EQ;
    peek();
    check("eq_cond_ready", 32'(bus_if.cond_ready), 32'h1);
    step();
    bus_if.cond_valid = 1'b0;
    peek();
    check("eq_res_valid", 32'(bus_if.res_valid), 32'h1);
    check("eq_res_taken", 32'(bus_if.res_taken), 32'h1);
    check("eq_flags", 32'(flags_q), 32'h4);

    // GE query behind a pending flag op.
    do_reset();
    bus_if.issue_flag_op = 1'b1;
    step();
    bus_if.issue_flag_op = 1'b0;
    bus_if.cond_valid    = 1'b1;
    bus_if.cond_code     = COND_GE;
    peek();
    check("ge_stall", 32'(bus_if.cond_ready), 32'h0);
    step();
    flag_write(4'b1000);
    peek();
`ifdef COND_BYPASS_EN
    check("ge_bypass_accept", 32'(bus_if.cond_ready), 32'h1);
    step();
    flag_off();
    bus_if.cond_valid = 1'b0;
`else
    check("ge_wait_write", 32'(bus_if.cond_ready), 32'h0);
    step();
    flag_off();
    peek();
    check("ge_accept_after", 32'(bus_if.cond_ready), 32'h1);
    step();
    bus_if.cond_valid = 1'b0;
`endif
    peek();
    check("ge_res_valid", 32'(bus_if.res_valid), 32'h1);
    check("ge_res_taken", 32'(bus_if.res_taken), 32'h0);

    // Four consecutive issues against PEND_MAX=3.
    do_reset();
    bus_if.issue_flag_op = 1'b1;
    for (int i = 0; i < 4; i++) begin
      peek();
      check("issue_ready_seq", 32'(bus_if.issue_ready), (i < 3) ? 32'h1 : 32'h0);
      step();
    end
    bus_if.issue_flag_op = 1'b0;
    peek();
    check("issue_ready_full", 32'(bus_if.issue_ready), 32'h0);
    flag_write(4'b0000);
    step();
    flag_off();
    peek();
    check("issue_ready_drain", 32'(bus_if.issue_ready), 32'h1);

    // Simultaneous issue and flag write at pending 1.
    do_reset();
    bus_if.issue_flag_op = 1'b1;
    step();
    flag_write(4'b0001);
    bus_if.cond_valid = 1'b1;
    bus_if.cond_code  = COND_CS;
    peek();
    check("sim_stall", 32'(bus_if.cond_ready), 32'h0);
    step();
    bus_if.issue_flag_op = 1'b0;
    flag_off();
    peek();
    check("sim_still_pending", 32'(bus_if.cond_ready), 32'h0);
    flag_write(4'b0001);
`ifdef COND_BYPASS_EN
    step();
    flag_off();
    bus_if.cond_valid = 1'b0;
`else
    step();
    flag_off();
    step();
    bus_if.cond_valid = 1'b0;
`endif
    peek();
    check("sim_res_valid", 32'(bus_if.res_valid), 32'h1);
    check("sim_res_taken", 32'(bus_if.res_taken), 32'h1);

    // Sticky underflow until reset.
    do_reset();
    peek();
    check("uf_clear", 32'(err_underflow), 32'h0);
    flag_write(4'b1111);
    step();
    flag_off();
    step(); step(); step();
    peek();
    check("uf_sticky", 32'(err_underflow), 32'h1);
    do_reset();
    peek();
    check("uf_reset", 32'(err_underflow), 32'h0);

    // Full sweep: every condition code over every flag value, back-to-back.
    for (int f = 0; f < 16; f++) begin
      flag_write(4'(f));
      step();
      flag_off();
      bus_if.cond_valid = 1'b1;
      for (int c = 0; c < 16; c++) begin
        bus_if.cond_code = 4'(c);
        step();
        peek();
        if (f == 9 && c == 8)   check("pin_hi_1001", 32'(bus_if.res_taken), 32'h1);
        if (f == 10 && c == 10) check("pin_ge_1010", 32'(bus_if.res_taken), 32'h1);
        if (f == 10 && c == 12) check("pin_gt_1010", 32'(bus_if.res_taken), 32'h1);
        if (f == 6 && c == 11)  check("pin_lt_0110", 32'(bus_if.res_taken), 32'h1);
        if (f == 6 && c == 12)  check("pin_gt_0110", 32'(bus_if.res_taken), 32'h0);
        if (f == 0 && c == 15)  check("pin_nv_0000", 32'(bus_if.res_taken), 32'h0);
        if (f == 0 && c == 14)  check("pin_al_0000", 32'(bus_if.res_taken), 32'h1);
      end
      bus_if.cond_valid = 1'b0;
      step();
    end

    // Randomized traffic with held queries and occasional reset.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (!bus_if.cond_valid || m_qacc) begin
        bus_if.cond_valid = ($urandom_range(0, 2) != 0);
        bus_if.cond_code  = 4'($urandom_range(0, 15));
      end
      bus_if.issue_flag_op = ($urandom_range(0, 2) == 0);
      bus_if.alu_valid     = ($urandom_range(0, 2) == 0);
      bus_if.flag_we       = ($urandom_range(0, 4) != 0);
      bus_if.flags_in      = 4'($urandom_range(0, 15));
      step();
    end

    rst = 1'b0;
    idle();
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
